// File: rtl/m_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m_mem_arbiter
// Purpose  : Arbitrates one 8-bit CPU port and NUM_REQ 8/16-bit DMA
//            requesters onto a single memory bus. Handles the HOLD/HLDA
//            bus-release handshake, SRAM/DRAM/ROM decode, byte-lane
//            steering and per-region wait states.
// Revision : 1.0 - initial release
// ============================================================================
module m_mem_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int SRAM_WAIT = 0,
  parameter int DRAM_WAIT = 1,
  parameter int ROM_WAIT  = 1
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [19:0]             cpu_addr,
  input  logic [7:0]              cpu_wdata,
  output logic [7:0]              cpu_rdata,
  output logic                    cpu_ack,
  input  logic [NUM_REQ-1:0]      dma_req,
  input  logic [NUM_REQ-1:0]      dma_we,
  input  logic [NUM_REQ-1:0]      dma_word,
  input  logic [20*NUM_REQ-1:0]   dma_addr,
  input  logic [16*NUM_REQ-1:0]   dma_wdata,
  output logic [15:0]             dma_rdata,
  output logic [NUM_REQ-1:0]      dma_ack,
  output logic                    hold,
  input  logic                    hlda,
  output logic [19:0]             mem_addr,
  output logic [15:0]             mem_wdata,
  output logic [1:0]              mem_be,
  output logic                    mem_we,
  output logic [2:0]              mem_sel,
  input  logic [15:0]             mem_rdata
);

  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_WAIT = (SRAM_WAIT > DRAM_WAIT) ?
                            ((SRAM_WAIT > ROM_WAIT) ? SRAM_WAIT : ROM_WAIT) :
                            ((DRAM_WAIT > ROM_WAIT) ? DRAM_WAIT : ROM_WAIT);
  // Counter holds WAIT+1 down to 0, giving WAIT+2 access cycles.
  localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 2) : 1;

  localparam logic [1:0] C_REG_SRAM = 2'b00;
  localparam logic [1:0] C_REG_DRAM = 2'b10;
  localparam logic [1:0] C_REG_ROM  = 2'b11;

  // How the read-data register is filled on the last access cycle.
  localparam logic [1:0] C_RD_FULL = 2'd0;
  localparam logic [1:0] C_RD_LO   = 2'd1;
  localparam logic [1:0] C_RD_HI   = 2'd2;
  localparam logic [1:0] C_RD_ONES = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOLD_WAIT = 2'd1,
    S_ACC       = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               cpu_gnt_q, cpu_gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_q, hold_d;
  logic [19:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [1:0]         be_q, be_d;
  logic [2:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic               first_q, first_d;
  logic [1:0]         rdmode_q, rdmode_d;
  logic [15:0]        rdata_q, rdata_d;

  logic               any_req;
  logic [IDX_W-1:0]   rr_idx;
  logic               hi_found;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_idx;

  logic [19:0]        src_addr;
  logic               src_we;
  logic               src_word;
  logic [15:0]        src_wd16;
  logic [1:0]         region;
  logic               mapped;
  logic [19:0]        ld_addr;
  logic [15:0]        ld_wdata;
  logic [1:0]         ld_be;
  logic [2:0]         ld_sel;
  logic [CNT_W-1:0]   ld_cnt;
  logic               ld_we;
  logic [1:0]         ld_rdmode;
  logic               load;
  logic [15:0]        rd_steered;

  assign any_req = |dma_req;

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dma_req[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  // Source mux, region decode and byte-lane steering for the access being granted.
  always_comb begin
    src_addr = cpu_addr;
    src_we   = cpu_we;
    src_word = 1'b0;
    src_wd16 = {8'h00, cpu_wdata};
    if (any_req) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IDX_W'(i) == rr_idx) begin
          src_addr = dma_addr[20*i +: 20];
          src_we   = dma_we[i];
          src_word = dma_word[i];
          src_wd16 = dma_wdata[16*i +: 16];
        end
      end
    end

    region  = src_addr[19:18];
    ld_addr = src_addr;
    mapped  = 1'b1;
    ld_sel  = 3'b000;
    ld_cnt  = '0;
    case (region)
      C_REG_SRAM: begin ld_sel = 3'b001; ld_cnt = CNT_W'(SRAM_WAIT + 1); end
      C_REG_DRAM: begin ld_sel = 3'b010; ld_cnt = CNT_W'(DRAM_WAIT + 1); end
      C_REG_ROM:  begin ld_sel = 3'b100; ld_cnt = CNT_W'(ROM_WAIT + 1);  end
      default:    mapped = 1'b0;
    endcase

    if (src_word) begin
      ld_wdata = src_wd16;
      if (region == C_REG_SRAM) begin
        ld_be      = 2'b11;
        ld_addr[0] = 1'b0;
        ld_rdmode  = C_RD_FULL;
      end else begin
        // DRAM/ROM are only 8 bits wide: word access uses the low lane.
        ld_be     = 2'b01;
        ld_rdmode = C_RD_LO;
      end
    end else begin
      ld_wdata  = {src_wd16[7:0], src_wd16[7:0]};
      ld_be     = src_addr[0] ? 2'b10 : 2'b01;
      ld_rdmode = src_addr[0] ? C_RD_HI : C_RD_LO;
    end

    if (!mapped) begin
      ld_rdmode = C_RD_ONES;
    end
    ld_we = src_we && mapped && (region != C_REG_ROM);
  end

  // Lane selection applied to mem_rdata on the final access cycle.
  always_comb begin
    case (rdmode_q)
      C_RD_FULL: rd_steered = mem_rdata;
      C_RD_LO:   rd_steered = {8'h00, mem_rdata[7:0]};
      C_RD_HI:   rd_steered = {8'h00, mem_rdata[15:8]};
      default:   rd_steered = 16'hFFFF;
    endcase
  end

  // Arbitration FSM next-state logic and access setup.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cpu_gnt_d = cpu_gnt_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    sel_d     = sel_q;
    we_d      = we_q;
    first_d   = first_q;
    rdmode_d  = rdmode_q;
    rdata_d   = rdata_q;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          hold_d = 1'b1;
          if (hlda) begin
            load      = 1'b1;
            cpu_gnt_d = 1'b0;
            gidx_d    = rr_idx;
            state_d   = S_ACC;
          end else begin
            state_d = S_HOLD_WAIT;
          end
        end else begin
          hold_d = 1'b0;
          if (cpu_req && !hlda) begin
            load      = 1'b1;
            cpu_gnt_d = 1'b1;
            state_d   = S_ACC;
          end
        end
      end
      S_HOLD_WAIT: begin
        hold_d = 1'b1;
        if (hlda) begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        first_d = 1'b0;
        if (cnt_q == '0) begin
          rdata_d = rd_steered;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (!cpu_gnt_q) begin
          ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      addr_d   = ld_addr;
      wdata_d  = ld_wdata;
      be_d     = ld_be;
      sel_d    = ld_sel;
      we_d     = ld_we;
      cnt_d    = mapped ? ld_cnt : '0;
      rdmode_d = ld_rdmode;
      first_d  = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      cpu_gnt_q <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      first_q   <= 1'b0;
      rdmode_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      cpu_gnt_q <= cpu_gnt_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      first_q   <= first_d;
      rdmode_q  <= rdmode_d;
      rdata_q   <= rdata_d;
    end
  end

  // One-hot DMA completion pulse during DONE.
  always_comb begin
    dma_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dma_ack[i] = (state_q == S_DONE) && !cpu_gnt_q && (gidx_q == IDX_W'(i));
    end
  end

  assign cpu_ack   = (state_q == S_DONE) && cpu_gnt_q;
  assign cpu_rdata = rdata_q[7:0];
  assign dma_rdata = rdata_q;
  assign hold      = hold_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_sel   = (state_q == S_ACC) ? sel_q : 3'b000;
  assign mem_be    = (state_q == S_ACC) ? be_q : 2'b00;
  assign mem_we    = (state_q == S_ACC) && first_q && we_q;

endmodule
`default_nettype wire

// File: doc/m_mem_arbiter.md
Name: m_mem_arbiter

Overview:
Parametrised successor to the fixed CPU/SlipStream bus mux in the Konix top level. It arbitrates one 8-bit CPU port and NUM_REQ 8/16-bit DMA requesters onto a single memory bus. It owns the HOLD/HLDA bus-release handshake, SRAM/DRAM/ROM region decode, byte-lane steering and per-region wait states. It sits between m8088, the SlipStream/DMA masters and the RAM board models.

Parameters:
NUM_REQ, 2, number of DMA requesters (1..4)
SRAM_WAIT, 0, extra access cycles for region addr[19:18]=00
DRAM_WAIT, 1, extra access cycles for region 10
ROM_WAIT, 1, extra access cycles for region 11

Ports:
clk_sys  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; level, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  20  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data; valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
dma_req  in  NUM_REQ  per-requester request; level, held until ack
dma_we  in  NUM_REQ  per-requester write flag
dma_word  in  NUM_REQ  1=16-bit access, 0=8-bit access
dma_addr  in  20*NUM_REQ  packed; requester i uses bits [20i+19:20i]
dma_wdata  in  16*NUM_REQ  packed write data
dma_rdata  out  16  read data; valid while the matching dma_ack bit=1
dma_ack  out  NUM_REQ  one-hot, one-cycle completion pulse
hold  out  1  bus request to CPU
hlda  in  1  CPU bus-release acknowledge
mem_addr  out  20  memory address
mem_wdata  out  16  memory write data
mem_be  out  2  byte enables: bit0=even lane, bit1=odd lane
mem_we  out  1  write strobe
mem_sel  out  3  one-hot region select: bit0 SRAM, bit1 DRAM, bit2 ROM
mem_rdata  in  16  registered memory read data (one-cycle read latency)

Behaviour:
- Reset: all outputs 0; FSM=IDLE; round-robin pointer=0; wait counter=0. Reset mid-access aborts the access with no ack; the outputs are 0 on the cycle after reset is sampled.
- FSM states: IDLE, HOLD_WAIT, ACC, DONE.
- IDLE:
  - If any dma_req=1 and hlda=1: grant the first requesting index at or after the pointer (round-robin), then go to ACC.
  - If any dma_req=1 and hlda=0: set hold=1, go to HOLD_WAIT.
  - Else if cpu_req=1 and hlda=0: grant the CPU, go to ACC.
  - Else if no dma_req: hold=0.
- HOLD_WAIT: hold=1; stay until hlda=1, then return to IDLE. DMA therefore always beats the CPU, but a CPU access already in ACC finishes first.
- hold stays 1 while any dma_req=1. It drops in IDLE when dma_req==0.
- The CPU is never granted while hlda=1.
- Decode on addr[19:18]: 00 SRAM, 10 DRAM, 11 ROM, 01 unmapped.
- ACC:
  - Lasts WAIT+2 cycles for the decoded region.
  - mem_addr, mem_sel and mem_be are held stable for the whole state.
  - mem_we=1 on the first ACC cycle only, for writes.
  - On the last ACC cycle the read-data register is loaded from mem_rdata.
- DONE: one cycle. The matching ack=1 and read data is valid. Return to IDLE. After a DMA grant, pointer = grant+1 mod NUM_REQ.
- Requester rule: req must fall on the clock edge where ack is seen. A req still high in IDLE starts a new access.
- Lane steering, CPU byte access:
  - mem_be = addr[0] ? 10 : 01.
  - Write data is replicated on both lanes.
  - cpu_rdata = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0].
- Lane steering, DMA word access:
  - SRAM: mem_be=11, addr[0] forced to 0, full 16-bit data.
  - DRAM/ROM: low lane only, mem_be=01, dma_rdata[15:8]=0.
- DMA byte access: steered like a CPU byte access; dma_rdata = {8'h00, byte}.
- ROM writes: mem_we is suppressed; ack is still returned.
- Unmapped access: no mem_sel, no mem_we. ACC lasts 1 cycle, then DONE with read data 16'hFFFF (cpu_rdata=8'hFF).
- Simultaneous cpu_req and dma_req in IDLE: DMA wins. The CPU waits until hold falls and hlda falls.

Test Plan:
- CPU read of 0x00001, SRAM_WAIT=0, mem_rdata=16'hA55A: mem_sel=001 and mem_be=10 for 2 cycles; cpu_ack 3 cycles after req; cpu_rdata=8'hA5.
- dma_req[0] word write 0x00003 data 16'h1234, hlda raised 2 cycles after hold: mem_addr=0x00002, mem_be=11, mem_we pulses once, dma_ack[0] pulses once; hold falls after req drops.
- dma_req=2'b11 held, pointer=0: grants alternate 0,1,0,1; each ack is one-hot.
- DRAM read 0x80000 with DRAM_WAIT=1, dma_word=1: ACC lasts 3 cycles, mem_be=01, dma_rdata=16'h00xx.
- CPU read 0x40000 (unmapped): mem_sel=000 throughout, cpu_rdata=8'hFF; CPU write to 0xC0000 (ROM): mem_we stays 0 and cpu_ack still pulses.
- reset asserted on the second ACC cycle: no ack; hold, mem_sel and mem_we are 0 the next cycle; the next cpu_req completes normally.
